// File: rtl/shr_pkg.sv
// Opcode constants and sequencer state encoding shared by the shift-register
// datapath and everything that drives its opcode.
package shr_pkg;

  localparam logic [1:0] OPR_SHIFT = 2'd0;
  localparam logic [1:0] OPR_HOLD  = 2'd1;
  localparam logic [1:0] OPR_CLR   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/shr_bit_cnt.sv
// Shift-cycle counter: synchronous clear, enable, saturates at N-1 (terminal count).
// Registered count, tc decoded combinationally from it; no handshake.
module shr_bit_cnt #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o  = (cnt_q == CW'(N - 1));
  assign cnt_o = cnt_q;

  // Holding at terminal count keeps the counter from wrapping inside a command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/shr_load_seq.sv
// Converts load/clear commands into shift-register opcodes; load done N+1 cycles after accept.
// cmd_ready only in IDLE. SHR_LOAD_SEQ_PRECLR_EN inserts a clear cycle before every load.
module shr_load_seq
  import shr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_clr,
  input  logic [N-1:0] cmd_data,
  output logic [1:0]   opr,
  output logic         r,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_t        state_q, state_d;
  logic [1:0]    opr_q, opr_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  word_q, word_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          tc;
  logic          accept;
  logic          cnt_clr;
  logic          cnt_en;
  logic          go_shift;

  shr_bit_cnt #(.N(N), .CW(CW)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign cnt_inc   = cnt + 1'b1;

`ifdef SHR_LOAD_SEQ_PRECLR_EN
  // Remembers whether the CLR cycle belongs to a load (continue into SHIFT).
  logic load_q, load_d;
  assign go_shift = load_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= 1'b0;
    end else begin
      load_q <= load_d;
    end
  end

  always_comb begin
    load_d = load_q;
    if (accept) begin
      load_d = ~cmd_clr;
    end
  end
`else
  assign go_shift = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    word_d  = word_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        opr_d  = OPR_HOLD;
        r_d    = 1'b0;
        busy_d = 1'b0;
        if (accept) begin
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
          if (cmd_clr) begin
            state_d = CLR;
            opr_d   = OPR_CLR;
          end else begin
            word_d = cmd_data;
`ifdef SHR_LOAD_SEQ_PRECLR_EN
            state_d = CLR;
            opr_d   = OPR_CLR;
`else
            state_d = SHIFT;
            opr_d   = OPR_SHIFT;
            r_d     = cmd_data[0];
`endif
          end
        end
      end
      CLR: begin
        if (go_shift) begin
          state_d = SHIFT;
          opr_d   = OPR_SHIFT;
          r_d     = word_q[0];
        end else begin
          state_d = FIN;
          opr_d   = OPR_HOLD;
          r_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      SHIFT: begin
        // r already presents word[cnt]; line up the next bit for the following cycle.
        cnt_en = 1'b1;
        if (tc) begin
          state_d = FIN;
          opr_d   = OPR_HOLD;
          r_d     = 1'b0;
          done_d  = 1'b1;
        end else begin
          r_d = word_q[cnt_inc];
        end
      end
      FIN: begin
        state_d = IDLE;
        opr_d   = OPR_HOLD;
        r_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        opr_d   = OPR_HOLD;
        r_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opr_q   <= OPR_HOLD;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      word_q  <= word_d;
    end
  end

  assign opr  = opr_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shr_load_seq.sv
// Bench for shr_load_seq driving a behavioural right-shift register; directed and random commands.
module tb_shr_load_seq;

  localparam int N = 4;
`ifdef SHR_LOAD_SEQ_PRECLR_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_clr;
  logic [N-1:0] cmd_data;
  logic [1:0]   opr;
  logic         r;
  logic         busy;
  logic         done;
  logic [N-1:0] q = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shr_load_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clr   (cmd_clr),
    .cmd_data  (cmd_data),
    .opr       (opr),
    .r         (r),
    .busy      (busy),
    .done      (done)
  );

  // Shift register under sequencer control: r enters at the MSB.
  always @(posedge clk) begin
    case (opr)
      2'd0:    q <= {r, q[N-1:1]};
      2'd2:    q <= '0;
      default: q <= q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_opr"}, opr, 32'd1);
    chk({tag, "_r"}, r, 32'd0);
    chk({tag, "_done"}, done, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_ready"}, cmd_ready, 32'd1);
  endtask

  // Called at a negedge. Presents a command, follows it to done and the following IDLE cycle.
  task automatic run_cmd(input logic clr, input logic [N-1:0] data, input logic keep,
                         input logic nclr, input logic [N-1:0] ndata);
    int len;
    int waitc;
    cmd_valid = 1'b1;
    cmd_clr   = clr;
    cmd_data  = data;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_wait", cmd_ready, 32'd1);
    @(posedge clk);
    len = clr ? 1 : PRE + N;
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = keep;
      chk("busy", busy, 32'd1);
      chk("ready_busy", cmd_ready, 32'd0);
      if (c <= len) begin
        chk("done_early", done, 32'd0);
        if (clr || c <= PRE) begin
          chk("opr_clr", opr, 32'd2);
        end else begin
          chk("opr_shift", opr, 32'd0);
          chk("r_bit", r, 32'(data[c-PRE-1]));
        end
        cmd_data = N'($urandom);
        if (keep) cmd_clr = 1'($urandom);
      end else begin
        chk("done", done, 32'd1);
        chk("opr_fin", opr, 32'd1);
        chk("q_final", q, clr ? 32'd0 : 32'(data));
        if (keep) begin
          cmd_data = ndata;
          cmd_clr  = nclr;
        end
      end
    end
    @(negedge clk);
    idle_chk("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic         cur_clr, nclr, keep;
    logic [N-1:0] cur_data, ndata;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_clr = 1'b0;
    cmd_data = '0;
    repeat (2) @(negedge clk);
    idle_chk("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_chk("idle");
    end

    run_cmd(1'b0, 4'b1011, 1'b0, 1'b0, '0);
    run_cmd(1'b0, 4'hF, 1'b0, 1'b0, '0);
    chk("q_before_clr", q, 32'hF);
    run_cmd(1'b1, 4'h3, 1'b0, 1'b0, '0);

    run_cmd(1'b0, 4'h5, 1'b1, 1'b0, 4'hA);
    run_cmd(1'b0, 4'hA, 1'b0, 1'b0, '0);

    // Reset in the middle of a load.
    cmd_valid = 1'b1;
    cmd_clr   = 1'b0;
    cmd_data  = 4'hC;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_opr", opr, (PRE != 0) ? 32'd0 : 32'd0);
    #2 rst = 1'b1;
    #1 idle_chk("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_chk("after_rst");
    end
    run_cmd(1'b0, 4'h6, 1'b0, 1'b0, '0);
    run_cmd(1'b0, 4'h9, 1'b0, 1'b0, '0);

    cur_clr  = 1'b0;
    cur_data = N'($urandom);
    for (int i = 0; i < 25; i++) begin
      nclr  = ($urandom_range(0, 3) == 0);
      ndata = N'($urandom);
      keep  = 1'($urandom);
      run_cmd(cur_clr, cur_data, keep, nclr, ndata);
      cur_clr  = nclr;
      cur_data = ndata;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shr_load_seq.md
# shr_load_seq

Sequencer that owns the 2-bit opcode and serial input of an N-bit right-shift register (opcodes: shift-right-with-serial-in, hold, clear). It accepts parallel load/clear commands over a valid/ready handshake and converts each load into N consecutive shift cycles, feeding the word LSB-first so it lands bit-aligned in the register. It then holds the register and reports completion. It sits between command logic and the shift-register datapath, which it drives exclusively.

## Interface
- N, default 4: register width and shifts per load; N ≥ 2.
- clk  in  1  rising-edge clock, shared with the shift register.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_clr  in  1  1 = clear command, 0 = load command.
- cmd_data  in  N  word to load; ignored when cmd_clr=1.
- opr  out  2  opcode to the shift register: 0 shift, 1 hold, 2 clear (3 never driven).
- r  out  1  serial bit to the shift register's MSB input.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse: the register content is final this cycle.

## Operation
- States:
  - IDLE: opr=1, r=0, cmd_ready=1, busy=0.
  - CLR: one cycle, opr=2.
  - SHIFT: N cycles, opr=0.
  - FIN: one cycle, opr=1, done=1.
- Transitions:
  - IDLE, no accept → IDLE.
  - Accept (cmd_valid & cmd_ready) with cmd_clr=1 → CLR, then FIN.
  - Accept with cmd_clr=0: cmd_data is captured into an internal N-bit word register, the bit counter is zeroed, and the state goes to SHIFT.
  - SHIFT: in shift cycle k (k=0..N-1), r = word[k]. The counter increments and the state goes to FIN after k=N-1.
  - FIN → IDLE.
- Because the register shifts right with r entering at MSB, bit word[k] ends at position k after N shifts.
- cmd_ready=1 only in IDLE. Commands presented while busy are not accepted; the requester must hold cmd_valid and cmd_data stable until accepted.
- cmd_data is sampled only on the accept edge. Later changes have no effect.
- Counter width $clog2(N). The counter does not wrap past N-1 within a command.

## Timing
- All outputs (opr, r, busy, done) are registered, except cmd_ready, which is decoded from state.
- Reset values: state IDLE, opr=1 (hold), r=0, busy=0, done=0, cmd_ready=1, counter 0, word register 0.
- Load, with the accept edge at end of cycle 0:
  - Cycles 1..N: opr=0, r=cmd_data[0..N-1].
  - Cycle N+1: opr=1, done=1, register q = cmd_data.
  - Cycle N+2: IDLE, and a new accept is possible at the end of that cycle.
  - Latency from accept to done is N+1 cycles. Throughput is one load per N+2 cycles.
- Clear: cycle 1 opr=2, cycle 2 done=1 with q=0, cycle 3 IDLE.
- busy=1 from the cycle after accept through the done cycle inclusive.
- rst asserted mid-command: outputs go immediately to reset values and the partial shift is abandoned. The shift register content is then undefined, and the sequencer does not clear it.
- cmd_valid with cmd_clr toggling while not ready has no effect. The cmd_clr value at the accept edge decides the command.

## Configuration
- SHR_LOAD_SEQ_PRECLR_EN: when defined, every load command inserts one CLR cycle (opr=2) before SHIFT.
  - Load latency becomes N+2 cycles and throughput one load per N+3 cycles.
  - Clear commands are unchanged.
- Without the macro, loads go straight to SHIFT as described above.

## Structure
- Shared package shr_pkg:
  - opcode localparams OPR_SHIFT=2'd0, OPR_HOLD=2'd1, OPR_CLR=2'd2;
  - state typedef (IDLE, CLR, SHIFT, FIN).
  - The shift register and any other opcode user import the same constants.
- One sub-module: shr_bit_cnt, the $clog2(N)-bit counter with clear, enable and terminal-count (count==N-1) outputs.
- The FSM, word register and output registers stay in shr_load_seq.

## Test plan
- Reset then idle, N=4: after rst release, opr=1, r=0, done=0, busy=0, cmd_ready=1 for 10 cycles with cmd_valid=0.
- Load 4'b1011 and connect the sequencer to the shift register model: r sequence 1,1,0,1 over cycles 1–4 with opr=0; done in cycle 5 with q=4'b1011.
- Clear after load, with q=4'b1111: opr=2 for one cycle, done the next cycle with q=0, then cmd_ready=1.
- Back-to-back: cmd_valid held high with 4'h5 then 4'hA. The second accept occurs only in the IDLE cycle after done. q=5 at the first done, q=A at the second, and cmd_data changes while busy are ignored.
- Reset mid-shift: assert rst during shift cycle 2. Outputs return to reset values in the same cycle, no done pulse, and the next load 4'h6 completes normally.
- With SHR_LOAD_SEQ_PRECLR_EN, load 4'h9: opr=2 in cycle 1, opr=0 in cycles 2–5, done in cycle 6 with q=4'h9.
